// File: rtl/apb_reg_strobe_decoder.sv
// APB slave-side register-access decoder.
// Tracks the APB setup/access handshake, optionally inserts wait states, and
// produces one-hot read/write strobes, clear-on-read pulses and sticky read
// indications for up to 16 registers. Every output is a flop (Moore).
module apb_reg_strobe_decoder #(
    parameter int unsigned NUM_REGS    = 6,
    parameter int unsigned ADDR_LSB    = 2,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [15:0] RO_MASK     = 16'h0000,
    parameter logic [15:0] WO_MASK     = 16'h0001,
    parameter logic [15:0] RCLR_MASK   = 16'h0010,
    parameter logic [15:0] STICKY_MASK = 16'h0008
) (
    input  logic                pclk,
    input  logic                rst,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [31:0]         paddr,
    output logic [NUM_REGS-1:0] wr_stb,
    output logic [NUM_REGS-1:0] rd_stb,
    output logic [NUM_REGS-1:0] rclr_stb,
    output logic [NUM_REGS-1:0] rd_hold,
    output logic [3:0]          rd_idx,
    output logic                pready,
    output logic                pslverr
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAccess,
        StAbort
    } state_e;

    // Byte-offset bits that must be zero; expressed as a mask so that
    // ADDR_LSB=0 needs no special-case slice.
    localparam logic [31:0] LsbMask = (32'd1 << ADDR_LSB) - 32'd1;

    // Wait counter load value; counts down to zero inside WAIT.
    localparam logic [3:0] WaitInit = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [NUM_REGS-1:0] RclrVec   = RCLR_MASK[NUM_REGS-1:0];
    localparam logic [NUM_REGS-1:0] StickyVec = STICKY_MASK[NUM_REGS-1:0];

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [3:0]  idx_q;
    logic        write_q;
    logic        err_q;

    logic        setup;
    logic [3:0]  setup_idx;
    logic        setup_err;

    logic [3:0]  acc_idx;
    logic        acc_write;
    logic        acc_err;
    logic [NUM_REGS-1:0] acc_sel;
    logic [NUM_REGS-1:0] acc_wr_stb;
    logic [NUM_REGS-1:0] acc_rd_stb;
    logic [NUM_REGS-1:0] acc_rclr_stb;
    logic [NUM_REGS-1:0] sticky_hit;

    // Upper address bits are deliberately ignored.
    logic unused_paddr;
    assign unused_paddr = ^paddr;

    // One-hot decode of a register index; indices >= NUM_REGS decode to zero.
    function automatic logic [NUM_REGS-1:0] dec(input logic [3:0] idx);
        logic [NUM_REGS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == 4'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    // Decode the setup phase: register index and access-legality check.
    always_comb begin
        setup     = psel && !penable;
        setup_idx = paddr[ADDR_LSB+3:ADDR_LSB];
        setup_err = (32'(setup_idx) >= NUM_REGS)
                 || ((paddr & LsbMask) != 32'd0)
                 || (pwrite && RO_MASK[setup_idx])
                 || (!pwrite && WO_MASK[setup_idx]);
    end

    // Select the transfer attributes for the cycle that enters ACCESS: with no
    // wait states that is the setup itself, otherwise the latched copy.
    always_comb begin
        acc_idx   = idx_q;
        acc_write = write_q;
        acc_err   = err_q;
        if (state_q == StIdle) begin
            acc_idx   = setup_idx;
            acc_write = pwrite;
            acc_err   = setup_err;
        end
        acc_sel      = dec(acc_idx);
        acc_wr_stb   = (acc_write && !acc_err) ? acc_sel : '0;
        acc_rd_stb   = (!acc_write && !acc_err) ? acc_sel : '0;
        acc_rclr_stb = acc_rd_stb & RclrVec;
    end

    // Sticky bits contributed by the transfer currently in ACCESS.
    always_comb begin
        sticky_hit = '0;
        if (!write_q && !err_q) begin
            sticky_hit = dec(idx_q) & StickyVec;
        end
    end

    // Handshake FSM with registered strobes and response.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            idx_q    <= 4'd0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            wr_stb   <= '0;
            rd_stb   <= '0;
            rclr_stb <= '0;
            rd_hold  <= '0;
            rd_idx   <= 4'd0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
        end else begin
            // Strobes and response are single-cycle unless ACCESS is entered.
            wr_stb   <= '0;
            rd_stb   <= '0;
            rclr_stb <= '0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (setup) begin
                        idx_q   <= setup_idx;
                        write_q <= pwrite;
                        err_q   <= setup_err;
                        rd_idx  <= setup_idx;
                        rd_hold <= '0;
                        if (WAIT_STATES > 0) begin
                            state_q <= StWait;
                            cnt_q   <= WaitInit;
                        end else begin
                            state_q  <= StAccess;
                            wr_stb   <= acc_wr_stb;
                            rd_stb   <= acc_rd_stb;
                            rclr_stb <= acc_rclr_stb;
                            pready   <= 1'b1;
                            pslverr  <= acc_err;
                        end
                    end
                end

                StWait: begin
                    if (!psel || !penable) begin
                        // Master abandoned the transfer: no side effects.
                        state_q <= StAbort;
                        cnt_q   <= 4'd0;
                    end else if (cnt_q == 4'd0) begin
                        state_q  <= StAccess;
                        wr_stb   <= acc_wr_stb;
                        rd_stb   <= acc_rd_stb;
                        rclr_stb <= acc_rclr_stb;
                        pready   <= 1'b1;
                        pslverr  <= acc_err;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end

                StAccess: begin
                    rd_hold <= rd_hold | sticky_hit;
                    state_q <= StIdle;
                end

                StAbort: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Response and strobe sanity properties.
    a_err_needs_ready : assert property (@(posedge pclk) disable iff (rst) pslverr |-> pready);
    a_stb_onehot : assert property (@(posedge pclk) disable iff (rst) $onehot0({wr_stb, rd_stb}));
    a_stb_needs_ready : assert property (@(posedge pclk) disable iff (rst)
                                         (|{wr_stb, rd_stb}) |-> pready);

endmodule

// File: tb/tb_apb_reg_strobe_decoder.sv
// Bench for apb_reg_strobe_decoder: a zero-wait and a three-wait instance are
// driven with directed APB transfers; a transfer-log model predicts every
// output cycle by cycle, and literal checks pin the model's key results.
module tb_apb_reg_strobe_decoder;

    localparam int          NREGS  = 6;
    localparam logic [15:0] RO     = 16'h0000;
    localparam logic [15:0] WO     = 16'h0001;
    localparam logic [15:0] RCLR   = 16'h0010;
    localparam logic [15:0] STICKY = 16'h0008;

    typedef struct {
        int inst;
        int t;
        int idx;
        bit wr;
        bit err;
        bit ab;
    } xact_t;

    typedef struct packed {
        logic [5:0] wr;
        logic [5:0] rd;
        logic [5:0] rclr;
        logic [5:0] hold;
        logic [3:0] idx;
        logic       rdy;
        logic       serr;
    } outs_t;

    logic        pclk;
    logic        rst;
    logic        psel_a    [2];
    logic        penable_a [2];
    logic        pwrite_a  [2];
    logic [31:0] paddr_a   [2];
    logic [5:0]  wr_stb_a  [2];
    logic [5:0]  rd_stb_a  [2];
    logic [5:0]  rclr_stb_a[2];
    logic [5:0]  rd_hold_a [2];
    logic [3:0]  rd_idx_a  [2];
    logic        pready_a  [2];
    logic        pslverr_a [2];

    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;
    xact_t logq[$];

    // Captures from the most recent transfer.
    logic [5:0] acc_wr, acc_rd, acc_rclr;
    logic [3:0] acc_idx;
    logic       acc_rdy, acc_serr, wait_rdy, seen_rdy, seen_stb;

    apb_reg_strobe_decoder u_dut_w0 (
        .pclk    (pclk),
        .rst     (rst),
        .psel    (psel_a[0]),
        .penable (penable_a[0]),
        .pwrite  (pwrite_a[0]),
        .paddr   (paddr_a[0]),
        .wr_stb  (wr_stb_a[0]),
        .rd_stb  (rd_stb_a[0]),
        .rclr_stb(rclr_stb_a[0]),
        .rd_hold (rd_hold_a[0]),
        .rd_idx  (rd_idx_a[0]),
        .pready  (pready_a[0]),
        .pslverr (pslverr_a[0])
    );

    apb_reg_strobe_decoder #(
        .WAIT_STATES(3)
    ) u_dut_w3 (
        .pclk    (pclk),
        .rst     (rst),
        .psel    (psel_a[1]),
        .penable (penable_a[1]),
        .pwrite  (pwrite_a[1]),
        .paddr   (paddr_a[1]),
        .wr_stb  (wr_stb_a[1]),
        .rd_stb  (rd_stb_a[1]),
        .rclr_stb(rclr_stb_a[1]),
        .rd_hold (rd_hold_a[1]),
        .rd_idx  (rd_idx_a[1]),
        .pready  (pready_a[1]),
        .pslverr (pslverr_a[1])
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    function automatic bit calc_err(input bit wr, input logic [31:0] a);
        int idx;
        idx = int'((a >> 2) & 32'hF);
        if (idx >= NREGS) return 1'b1;
        if ((a & 32'h3) != 32'd0) return 1'b1;
        if (wr && ((RO >> idx) & 16'd1) != 16'd0) return 1'b1;
        if (!wr && ((WO >> idx) & 16'd1) != 16'd0) return 1'b1;
        return 1'b0;
    endfunction

    // Outputs in cycle c follow only from the last transfer whose setup came
    // before c: its response lands at setup+1+W, sticky reads persist after.
    function automatic outs_t model(input int inst, input int c);
        outs_t e;
        int    w;
        int    last;
        e    = '0;
        w    = (inst == 0) ? 0 : 3;
        last = -1;
        if (rst) return e;
        foreach (logq[i]) begin
            if (logq[i].inst == inst && logq[i].t < c) last = i;
        end
        if (last >= 0) begin
            xact_t tr;
            int    acc;
            logic [5:0] sel;
            tr    = logq[last];
            acc   = tr.t + 1 + w;
            sel   = 6'(32'd1 << tr.idx);
            e.idx = 4'(tr.idx);
            if (!tr.ab && c == acc) begin
                e.rdy  = 1'b1;
                e.serr = tr.err;
                if (!tr.err) begin
                    if (tr.wr) begin
                        e.wr = sel;
                    end else begin
                        e.rd = sel;
                        if (((RCLR >> tr.idx) & 16'd1) != 16'd0) e.rclr = sel;
                    end
                end
            end
            if (!tr.ab && c > acc && !tr.wr && !tr.err
                && ((STICKY >> tr.idx) & 16'd1) != 16'd0) begin
                e.hold = sel;
            end
        end
        return e;
    endfunction

    // Cycle-by-cycle compare of both instances against the model.
    always @(negedge pclk) begin
        for (int i = 0; i < 2; i++) begin
            outs_t g;
            outs_t e;
            g.wr   = wr_stb_a[i];
            g.rd   = rd_stb_a[i];
            g.rclr = rclr_stb_a[i];
            g.hold = rd_hold_a[i];
            g.idx  = rd_idx_a[i];
            g.rdy  = pready_a[i];
            g.serr = pslverr_a[i];
            e = model(i, cyc);
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL model_i%0d cyc %0d: got wr=%b rd=%b rclr=%b hold=%b idx=%0d rdy=%b serr=%b, required wr=%b rd=%b rclr=%b hold=%b idx=%0d rdy=%b serr=%b",
                         i, cyc, g.wr, g.rd, g.rclr, g.hold, g.idx, g.rdy, g.serr,
                         e.wr, e.rd, e.rclr, e.hold, e.idx, e.rdy, e.serr);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic note(input int inst);
        seen_rdy = seen_rdy | pready_a[inst];
        seen_stb = seen_stb | (|{wr_stb_a[inst], rd_stb_a[inst], rclr_stb_a[inst]});
    endtask

    // One APB transfer; abort_k>0 drops penable in that wait cycle.
    task automatic xfer(input int inst, input bit wr, input logic [31:0] addr,
                        input int abort_k);
        int    w;
        xact_t x;
        w = (inst == 0) ? 0 : 3;
        psel_a[inst]    = 1'b1;
        penable_a[inst] = 1'b0;
        pwrite_a[inst]  = wr;
        paddr_a[inst]   = addr;
        x.inst = inst;
        x.t    = cyc;
        x.idx  = int'((addr >> 2) & 32'hF);
        x.wr   = wr;
        x.err  = calc_err(wr, addr);
        x.ab   = (abort_k > 0);
        logq.push_back(x);
        seen_rdy = 1'b0;
        seen_stb = 1'b0;
        step();
        penable_a[inst] = 1'b1;
        for (int k = 1; k <= w; k++) begin
            note(inst);
            if (k == abort_k) begin
                penable_a[inst] = 1'b0;
                step();
                note(inst);
                psel_a[inst] = 1'b0;
                step();
                return;
            end
            step();
        end
        wait_rdy = seen_rdy;
        note(inst);
        acc_wr   = wr_stb_a[inst];
        acc_rd   = rd_stb_a[inst];
        acc_rclr = rclr_stb_a[inst];
        acc_idx  = rd_idx_a[inst];
        acc_rdy  = pready_a[inst];
        acc_serr = pslverr_a[inst];
        step();
        psel_a[inst]    = 1'b0;
        penable_a[inst] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            psel_a[i]    = 1'b0;
            penable_a[i] = 1'b0;
            pwrite_a[i]  = 1'b0;
            paddr_a[i]   = 32'd0;
        end
        idle(3);
        chk("reset_pready", 32'(pready_a[0]), 32'd0);
        chk("reset_rd_idx", 32'(rd_idx_a[1]), 32'd0);
        rst = 1'b0;
        step();

        // Write reg 0.
        xfer(0, 1'b1, 32'h0, 0);
        chk("wr0_stb", 32'(acc_wr), 32'h01);
        chk("wr0_rdy_serr", {30'd0, acc_rdy, acc_serr}, 32'h2);

        // Clear-on-read reg 4.
        xfer(0, 1'b0, 32'h10, 0);
        chk("rd4_stb", 32'(acc_rd), 32'h10);
        chk("rd4_rclr", 32'(acc_rclr), 32'h10);
        chk("rd4_idx", 32'(acc_idx), 32'd4);

        // Sticky reg 3, held through idle, cleared by the next setup.
        xfer(0, 1'b0, 32'hC, 0);
        idle(10);
        chk("hold3_idle", 32'(rd_hold_a[0]), 32'h08);
        xfer(0, 1'b1, 32'h14, 0);
        chk("hold3_cleared", 32'(rd_hold_a[0]), 32'h00);
        chk("wr5_stb", 32'(acc_wr), 32'h20);

        // Error responses, back to back.
        xfer(0, 1'b0, 32'h0, 0);
        chk("err_wo_resp", {30'd0, acc_rdy, acc_serr}, 32'h3);
        chk("err_wo_stb", 32'({acc_wr, acc_rd, acc_rclr}), 32'd0);
        xfer(0, 1'b1, 32'h18, 0);
        chk("err_range_resp", {30'd0, acc_rdy, acc_serr}, 32'h3);
        chk("err_range_stb", 32'({acc_wr, acc_rd, acc_rclr}), 32'd0);
        xfer(0, 1'b0, 32'h2, 0);
        chk("err_misalign_resp", {30'd0, acc_rdy, acc_serr}, 32'h3);
        chk("err_misalign_stb", 32'({acc_wr, acc_rd, acc_rclr}), 32'd0);
        idle(2);

        // Three wait states.
        xfer(1, 1'b1, 32'h8, 0);
        chk("w3_wait_rdy", 32'(wait_rdy), 32'd0);
        chk("w3_wr2_stb", 32'(acc_wr), 32'h04);
        chk("w3_rdy", 32'(acc_rdy), 32'd1);
        xfer(1, 1'b0, 32'hC, 0);
        idle(3);
        chk("w3_hold3", 32'(rd_hold_a[1]), 32'h08);

        // Master abort in the second wait cycle.
        xfer(1, 1'b1, 32'h8, 2);
        chk("abort_rdy", 32'(seen_rdy), 32'd0);
        chk("abort_stb", 32'(seen_stb), 32'd0);
        chk("abort_hold", 32'(rd_hold_a[1]), 32'd0);
        idle(2);

        // Reset while in WAIT.
        begin
            xact_t x;
            psel_a[1]    = 1'b1;
            penable_a[1] = 1'b0;
            pwrite_a[1]  = 1'b1;
            paddr_a[1]   = 32'h8;
            x.inst = 1;
            x.t    = cyc;
            x.idx  = 2;
            x.wr   = 1'b1;
            x.err  = 1'b0;
            x.ab   = 1'b1;
            logq.push_back(x);
            step();
            penable_a[1] = 1'b1;
            step();
            chk("pre_rst_idx", 32'(rd_idx_a[1]), 32'd2);
            rst = 1'b1;
            logq.delete();
            #1;
            chk("rst_async_idx", 32'(rd_idx_a[1]), 32'd0);
            chk("rst_async_rdy", 32'(pready_a[1]), 32'd0);
            step();
            psel_a[1]    = 1'b0;
            penable_a[1] = 1'b0;
            step();
            rst = 1'b0;
            step();
        end
        xfer(1, 1'b1, 32'h4, 0);
        chk("post_rst_wr1", 32'(acc_wr), 32'h02);
        chk("post_rst_resp", {30'd0, acc_rdy, acc_serr}, 32'h2);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
